// File: rtl/fredkin_tcounter.sv
// fredkin_tcounter: WIDTH-stage synchronous T-flip-flop register/counter.
// The toggle, direction, enable, complement and next-state logic is built
// entirely from Fredkin (controlled-swap) cells: P=A, Q=A'B+AC, R=A'C+AB.
// Only the WIDTH state flops are behavioural.
// Mode 0 toggles bit i when t[i] is set. Mode 1 counts up or down.
// Define FREDKIN_TCOUNTER_TC_EN to add the terminal-count output tc.
// Cell outputs that a function does not need are collected in nets whose
// names contain "unused". These are the garbage outputs of reversible logic.

// Single Fredkin gate: A passes through and selects whether B and C are swapped.
module fredkin (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic p_o,
    output logic q_o,
    output logic r_o
);
    assign p_o = a_i;
    assign q_o = (~a_i & b_i) | (a_i & c_i);
    assign r_o = (~a_i & c_i) | (a_i & b_i);
endmodule

module fredkin_tcounter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             up,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
`ifdef FREDKIN_TCOUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Fan-out copies of the state: qBuf = q, qbBuf = ~q.
    logic [WIDTH-1:0] qBuf;
    logic [WIDTH-1:0] qbBuf;

    // andUp[i] is the AND of q[0..i-1], and andDn[i] is the AND of qb[0..i-1].
    // Bit 0 of each chain is a constant 1, so stage 0 always toggles when counting.
    logic [WIDTH-1:0] andUp;
    logic [WIDTH-1:0] andDn;

    logic [WIDTH-1:0] cntTog;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] togEn;

    logic [WIDTH-1:0][8:0] unusedStage;
    logic [WIDTH-2:0][3:0] unusedChain;

    assign andUp[0] = 1'b1;
    assign andDn[0] = 1'b1;

    // Per-stage datapath:
    // 1. Fan out q into true and complement copies.
    // 2. Select the count direction.
    // 3. Select between counter mode and independent-T mode.
    // 4. Gate the toggle with en.
    // 5. XOR the toggle into the state.
    // The XOR uses togEn as the swap control between q and ~q.
    for (genvar i = 0; i < WIDTH; i++) begin : gStage
        fredkin uFanQ (
            .a_i(state_q[i]), .b_i(1'b0), .c_i(1'b1),
            .p_o(unusedStage[i][0]), .q_o(qBuf[i]), .r_o(qbBuf[i])
        );
        fredkin uDirMux (
            .a_i(up), .b_i(andDn[i]), .c_i(andUp[i]),
            .p_o(unusedStage[i][1]), .q_o(cntTog[i]), .r_o(unusedStage[i][2])
        );
        fredkin uModeMux (
            .a_i(mode), .b_i(t[i]), .c_i(cntTog[i]),
            .p_o(unusedStage[i][3]), .q_o(tog[i]), .r_o(unusedStage[i][4])
        );
        fredkin uEnAnd (
            .a_i(en), .b_i(tog[i]), .c_i(1'b0),
            .p_o(unusedStage[i][5]), .q_o(unusedStage[i][6]), .r_o(togEn[i])
        );
        fredkin uXor (
            .a_i(togEn[i]), .b_i(qBuf[i]), .c_i(qbBuf[i]),
            .p_o(unusedStage[i][7]), .q_o(state_d[i]), .r_o(unusedStage[i][8])
        );
    end

    // Carry chains: each step ANDs one more state bit into the running product.
    // The chains are fed only from the flops, so no combinational loop exists.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : gChain
        fredkin uUpAnd (
            .a_i(qBuf[i]), .b_i(andUp[i]), .c_i(1'b0),
            .p_o(unusedChain[i][0]), .q_o(unusedChain[i][1]), .r_o(andUp[i+1])
        );
        fredkin uDnAnd (
            .a_i(qbBuf[i]), .b_i(andDn[i]), .c_i(1'b0),
            .p_o(unusedChain[i][2]), .q_o(unusedChain[i][3]), .r_o(andDn[i+1])
        );
    end

`ifdef FREDKIN_TCOUNTER_TC_EN
    logic       allOnes;
    logic       allZeros;
    logic       tcSel;
    logic       tcMode;
    logic [9:0] unusedTc;

    // Terminal count:
    // - Extend both chains across the top bit to get all-ones and all-zeros.
    // - Select between them by direction.
    // - Qualify the result with mode and en.
    fredkin uUpAll (
        .a_i(qBuf[WIDTH-1]), .b_i(andUp[WIDTH-1]), .c_i(1'b0),
        .p_o(unusedTc[0]), .q_o(unusedTc[1]), .r_o(allOnes)
    );
    fredkin uDnAll (
        .a_i(qbBuf[WIDTH-1]), .b_i(andDn[WIDTH-1]), .c_i(1'b0),
        .p_o(unusedTc[2]), .q_o(unusedTc[3]), .r_o(allZeros)
    );
    fredkin uTcMux (
        .a_i(up), .b_i(allZeros), .c_i(allOnes),
        .p_o(unusedTc[4]), .q_o(tcSel), .r_o(unusedTc[5])
    );
    fredkin uTcMode (
        .a_i(mode), .b_i(tcSel), .c_i(1'b0),
        .p_o(unusedTc[6]), .q_o(unusedTc[7]), .r_o(tcMode)
    );
    fredkin uTcEn (
        .a_i(en), .b_i(tcMode), .c_i(1'b0),
        .p_o(unusedTc[8]), .q_o(unusedTc[9]), .r_o(tc)
    );
`endif

    // State flops: reset loads RST_VAL. Otherwise the flops take the next state
    // built by the cells. That next state equals the held value when en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q  = state_q;
    assign qb = qbBuf;

endmodule

// File: tb/tb_fredkin_tcounter.sv
// tb_fredkin_tcounter: scoreboard bench for fredkin_tcounter.
// dut4 (WIDTH=4, RST_VAL=5) runs hand-computed directed vectors.
// dut8 (WIDTH=8) runs a random sequence against a behavioural model.
// Stimulus pushes expected values, and separate monitors pop and compare them.
module tb_fredkin_tcounter;

    localparam logic [3:0] RST4 = 4'h5;
    localparam logic [7:0] RST8 = 8'hC3;

    logic clk = 1'b0;

    // Free-running clock; inputs change on the falling edge.
    always #5 clk = ~clk;

    logic       rst4, en4, mode4, up4;
    logic [3:0] t4, q4, qb4;
    logic       tc4;
    logic       rst8, en8, mode8, up8;
    logic [7:0] t8, q8, qb8;
    logic       tc8;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [7:0] q;
        logic       tc;
        string      name;
    } expItem_t;

    expItem_t exp4Q[$];
    expItem_t exp8Q[$];

    fredkin_tcounter #(.WIDTH(4), .RST_VAL(RST4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .up(up4), .t(t4),
        .q(q4), .qb(qb4)
`ifdef FREDKIN_TCOUNTER_TC_EN
        , .tc(tc4)
`endif
    );

    fredkin_tcounter #(.WIDTH(8), .RST_VAL(RST8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .up(up8), .t(t8),
        .q(q8), .qb(qb8)
`ifdef FREDKIN_TCOUNTER_TC_EN
        , .tc(tc8)
`endif
    );

`ifndef FREDKIN_TCOUNTER_TC_EN
    assign tc4 = 1'b0;
    assign tc8 = 1'b0;
`endif

    // Compares one value and counts the result.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one directed vector on dut4 and queues its hand-computed result.
    task automatic applyStimulus(input string name, input logic r, input logic e, input logic m,
                                 input logic u, input logic [3:0] tt, input logic [3:0] expQ,
                                 input logic expTc);
        expItem_t it;
        @(negedge clk);
        rst4  = r;
        en4   = e;
        mode4 = m;
        up4   = u;
        t4    = tt;
        it.q    = {4'h0, expQ};
        it.tc   = expTc;
        it.name = name;
        exp4Q.push_back(it);
    endtask

    // Drives a random sequence on dut8 and queues the behavioural model result.
    task automatic applyRandomStimulus(input int cycles);
        logic [7:0] model;
        logic       r, e, m, u;
        logic [7:0] tt;
        expItem_t   it;
        @(negedge clk);
        rst8  = 1'b1;
        en8   = 1'b0;
        mode8 = 1'b0;
        up8   = 1'b0;
        t8    = 8'h00;
        model = RST8;
        it.q    = model;
        it.tc   = 1'b0;
        it.name = "rand_reset";
        exp8Q.push_back(it);
        for (int n = 0; n < cycles; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            tt = 8'($urandom);
            @(negedge clk);
            rst8  = r;
            en8   = e;
            mode8 = m;
            up8   = u;
            t8    = tt;
            if (r) begin
                model = RST8;
            end else if (e) begin
                if (m) model = u ? model + 8'd1 : model - 8'd1;
                else   model = model ^ tt;
            end
            it.q    = model;
            it.tc   = m & e & (u ? (model == 8'hFF) : (model == 8'h00));
            it.name = $sformatf("rand%0d", n);
            exp8Q.push_back(it);
        end
    endtask

    // Monitor for dut4: checks each queued expectation just after its edge.
    initial begin : monitor4
        expItem_t it4;
        forever begin
            @(posedge clk);
            #1;
            if (exp4Q.size() != 0) begin
                it4 = exp4Q.pop_front();
                checkOutput({it4.name, ".q"}, {4'h0, q4}, it4.q);
                checkOutput({it4.name, ".qb"}, {4'h0, qb4}, {4'h0, ~it4.q[3:0]});
`ifdef FREDKIN_TCOUNTER_TC_EN
                checkOutput({it4.name, ".tc"}, {7'h0, tc4}, {7'h0, it4.tc});
`endif
            end
        end
    end

    // Monitor for dut8: same scheme against the model-derived queue.
    initial begin : monitor8
        expItem_t it8;
        forever begin
            @(posedge clk);
            #1;
            if (exp8Q.size() != 0) begin
                it8 = exp8Q.pop_front();
                checkOutput({it8.name, ".q"}, q8, it8.q);
                checkOutput({it8.name, ".qb"}, qb8, ~it8.q);
`ifdef FREDKIN_TCOUNTER_TC_EN
                checkOutput({it8.name, ".tc"}, {7'h0, tc8}, {7'h0, it8.tc});
`endif
            end
        end
    end

    // Main sequence: directed and random runs in parallel, then drain and report.
    initial begin : mainSeq
        rst4 = 1'b1; en4 = 1'b0; mode4 = 1'b0; up4 = 1'b0; t4 = 4'h0;
        rst8 = 1'b1; en8 = 1'b0; mode8 = 1'b0; up8 = 1'b0; t8 = 8'h00;
        fork
            begin
                //            name         rst  en  mode up  t      q      tc
                applyStimulus("reset",     1,   0,  0,   0,  4'h0,  4'h5,  0);
                applyStimulus("tload",     0,   1,  0,   0,  4'hB,  4'hE,  0);
                applyStimulus("up1",       0,   1,  1,   1,  4'h0,  4'hF,  1);
                applyStimulus("upWrap",    0,   1,  1,   1,  4'h0,  4'h0,  0);
                applyStimulus("up3",       0,   1,  1,   1,  4'h0,  4'h1,  0);
                applyStimulus("down1",     0,   1,  1,   0,  4'h0,  4'h0,  1);
                applyStimulus("downWrap",  0,   1,  1,   0,  4'h0,  4'hF,  0);
                applyStimulus("down3",     0,   1,  1,   0,  4'h0,  4'hE,  0);
                applyStimulus("tclear",    0,   1,  0,   0,  4'hE,  4'h0,  0);
                applyStimulus("tA1",       0,   1,  0,   0,  4'hA,  4'hA,  0);
                applyStimulus("tA2",       0,   1,  0,   0,  4'hA,  4'h0,  0);
                applyStimulus("t5",        0,   1,  0,   0,  4'h5,  4'h5,  0);
                applyStimulus("tHold",     0,   1,  0,   1,  4'h0,  4'h5,  0);
                applyStimulus("enHold1",   0,   0,  1,   1,  4'h0,  4'h5,  0);
                applyStimulus("enHold2",   0,   0,  0,   0,  4'hF,  4'h5,  0);
                applyStimulus("enHold3",   0,   0,  1,   0,  4'h0,  4'h5,  0);
                applyStimulus("count6",    0,   1,  1,   1,  4'h0,  4'h6,  0);
                applyStimulus("count7",    0,   1,  1,   1,  4'h0,  4'h7,  0);
                applyStimulus("midReset",  1,   1,  1,   1,  4'h0,  4'h5,  0);
                applyStimulus("resume",    0,   1,  1,   1,  4'h0,  4'h6,  0);
                applyStimulus("modeDown",  0,   1,  1,   0,  4'h0,  4'h5,  0);
                applyStimulus("modeT",     0,   1,  0,   1,  4'h3,  4'h6,  0);
                applyStimulus("modeUp",    0,   1,  1,   1,  4'h0,  4'h7,  0);
                applyStimulus("resetNoEn", 1,   0,  0,   0,  4'h0,  4'h5,  0);
            end
            begin
                applyRandomStimulus(1000);
            end
        join
        repeat (2) @(posedge clk);
        #2;
        checkOutput("drain4", 8'(exp4Q.size()), 8'h00);
        checkOutput("drain8", 8'(exp8Q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
